// File: rtl/sram_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bus_bridge_pkg
//  Description : Shared types and constants for the SRAM-port to memory-bus
//                bridge: FSM state encoding, transaction owner encoding and
//                the fill word returned when a bus response times out.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_bus_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    // Word handed back to the core in place of read data after a timeout.
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage : sram_bus_bridge_pkg
`default_nettype wire

// File: rtl/bridge_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_watchdog
//  Description : Response watchdog. A saturating counter that is cleared when
//                a bus address phase is granted and advances every cycle the
//                bridge waits for a response. A sticky error flag records
//                that a timeout was taken; only reset clears it.
//  Ports       : clk, reset     - clock / async active-high reset
//                i_clear        - zero the counter
//                i_enable       - count this cycle (waiting for response)
//                i_trip         - the bridge is taking the timeout path
//                o_expired      - this is the last cycle of the wait budget
//                o_error        - sticky timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module bridge_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_trip,
    output logic o_expired,
    output logic o_error
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (i_trip) begin
            r_error <= 1'b1;
        end
    end

    // Expiry is flagged in the cycle whose increment brings the counter to
    // TIMEOUT, so the bridge waits exactly TIMEOUT cycles for a response.
    assign o_expired = i_enable && (r_count >= C_LAST);
    assign o_error   = r_error;

endmodule : bridge_watchdog
`default_nettype wire

// File: rtl/sram_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bus_bridge
//  Description : Arbitrates the core's instruction and data SRAM-style ports
//                onto one single-port memory bus (req/gnt address phase,
//                rvalid response). Data requests win ties. Cancelled fetches
//                are aborted before grant or have their completion hidden
//                after grant. A watchdog substitutes TIMEOUT_DATA when the
//                bus never responds.
//  Ports       : clk, reset, cancel
//                inst_*  - fetch request / completion
//                data_*  - load/store request / completion
//                bus_*   - shared memory bus
//                bus_timeout - sticky watchdog error
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_bus_bridge
    import sram_bus_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cancel,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_ready,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_ready,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_gnt,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                bus_timeout
);

    localparam int STRB_W = DATA_W / 8;

    state_t              r_state;
    owner_t              r_owner;
    logic [STRB_W-1:0]   r_wen;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_drop;
    logic                r_inst_ready;
    logic                r_data_ready;
    logic [DATA_W-1:0]   r_inst_rdata;
    logic [DATA_W-1:0]   r_data_rdata;

    state_t              w_state_nxt;
    owner_t              w_owner_nxt;
    logic [STRB_W-1:0]   w_wen_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic                w_drop_nxt;
    logic                w_inst_ready_nxt;
    logic                w_data_ready_nxt;
    logic [DATA_W-1:0]   w_inst_rdata_nxt;
    logic [DATA_W-1:0]   w_data_rdata_nxt;

    logic                w_cancel_inst;
    logic                w_wd_clear;
    logic                w_wd_enable;
    logic                w_wd_trip;
    logic                w_wd_expired;
    logic                w_wd_error;
    logic                w_resp_done;
    logic [DATA_W-1:0]   w_resp_val;

    // Cancel only ever concerns a fetch; data transactions ignore it.
    assign w_cancel_inst = cancel && (r_owner == OWN_INST);

    assign w_wd_clear  = (r_state == ST_ADDR) && bus_gnt;
    assign w_wd_enable = (r_state == ST_RESP);
    // A response in the final budget cycle still wins over the timeout.
    assign w_wd_trip   = w_wd_enable && !bus_rvalid && w_wd_expired;

    assign w_resp_done = w_wd_enable && (bus_rvalid || w_wd_expired);
    assign w_resp_val  = bus_rvalid ? bus_rdata : DATA_W'(TIMEOUT_DATA);

    bridge_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .i_trip    (w_wd_trip),
        .o_expired (w_wd_expired),
        .o_error   (w_wd_error)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_wen_nxt        = r_wen;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_drop_nxt       = r_drop;
        w_inst_ready_nxt = 1'b0;
        w_data_ready_nxt = 1'b0;
        w_inst_rdata_nxt = r_inst_rdata;
        w_data_rdata_nxt = r_data_rdata;

        case (r_state)
            ST_IDLE: begin
                if (data_req) begin
                    w_owner_nxt = OWN_DATA;
                    w_wen_nxt   = data_wen;
                    w_addr_nxt  = data_addr;
                    w_wdata_nxt = data_wdata;
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = ST_ADDR;
                end else if (inst_req) begin
                    w_owner_nxt = OWN_INST;
                    w_wen_nxt   = '0;
                    w_addr_nxt  = inst_addr;
                    w_wdata_nxt = '0;
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (bus_gnt) begin
                    // Once granted the transaction must run to completion
                    // on the bus; a cancel only hides its result.
                    w_state_nxt = ST_RESP;
                    if (w_cancel_inst) begin
                        w_drop_nxt = 1'b1;
                    end
                end else if (w_cancel_inst) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_RESP: begin
                if (w_cancel_inst) begin
                    w_drop_nxt = 1'b1;
                end
                if (w_resp_done) begin
                    w_state_nxt = ST_IDLE;
                    if (r_owner == OWN_DATA) begin
                        w_data_rdata_nxt = w_resp_val;
                        w_data_ready_nxt = 1'b1;
                    end else if (!(r_drop || w_cancel_inst)) begin
                        w_inst_rdata_nxt = w_resp_val;
                        w_inst_ready_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_INST;
            r_wen        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_drop       <= 1'b0;
            r_inst_ready <= 1'b0;
            r_data_ready <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_wen        <= w_wen_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_drop       <= w_drop_nxt;
            r_inst_ready <= w_inst_ready_nxt;
            r_data_ready <= w_data_ready_nxt;
            r_inst_rdata <= w_inst_rdata_nxt;
            r_data_rdata <= w_data_rdata_nxt;
        end
    end

    // Address-phase fields come straight from the request latch, so they
    // stay stable for as long as the grant is withheld.
    assign bus_req     = (r_state == ST_ADDR);
    assign bus_wr      = bus_req && (|r_wen);
    assign bus_wstrb   = bus_req ? r_wen : '0;
    assign bus_addr    = r_addr;
    assign bus_wdata   = r_wdata;

    assign inst_ready  = r_inst_ready;
    assign inst_rdata  = r_inst_rdata;
    assign data_ready  = r_data_ready;
    assign data_rdata  = r_data_rdata;
    assign bus_timeout = w_wd_error;

endmodule : sram_bus_bridge
`default_nettype wire

// File: doc/sram_bus_bridge.md
# sram_bus_bridge

- Sits directly downstream of the CPU core's instruction and data SRAM-style ports.
- Arbitrates the two request streams onto one shared single-port memory bus with a grant/response handshake.
- Returns read data and completion pulses to the core, which stalls its fetch and memory stages until they arrive.
- Honours the core's pipeline cancel by discarding stale instruction fetches.
- Runs a response timeout watchdog.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte strobes are DATA_W/8
- TIMEOUT, 255, maximum cycles to wait for bus_rvalid

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cancel  in  1  pipeline flush pulse from the write-back stage
- inst_req  in  1  fetch request; held with inst_addr until inst_ready
- inst_addr  in  ADDR_W  fetch address
- inst_rdata  out  DATA_W  fetched word; valid while inst_ready=1
- inst_ready  out  1  one-cycle completion pulse
- data_req  in  1  load/store request; held with its operands until data_ready
- data_wen  in  DATA_W/8  byte write enables; 0 means load
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load result; valid while data_ready=1
- data_ready  out  1  one-cycle completion pulse
- bus_req  out  1  address phase valid
- bus_wr  out  1  1 = write
- bus_wstrb  out  DATA_W/8  byte strobes
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_gnt  in  1  address phase accepted in this cycle
- bus_rvalid  in  1  response valid; issued for both reads and writes
- bus_rdata  in  DATA_W  read data
- bus_timeout  out  1  sticky watchdog error

## Operation
- FSM states: IDLE, ADDR, RESP.
- IDLE:
  - If data_req=1, latch the data request, set owner=DATA, go to ADDR.
  - Otherwise, if inst_req=1, latch the instruction request, set owner=INST, go to ADDR.
  - Data always wins simultaneous requests.
- ADDR:
  - bus_req=1; bus_addr, bus_wr (= |wen), bus_wstrb and bus_wdata come from the latched request.
  - On bus_gnt=1, clear the watchdog counter and go to RESP.
- RESP:
  - The watchdog counter increments each cycle.
  - On bus_rvalid=1, capture bus_rdata, pulse the owner's ready on the next cycle, and go to IDLE.
  - If the counter reaches TIMEOUT first, set bus_timeout, return DATA_W'hDEADBEEF with a ready pulse, and go to IDLE.
- cancel:
  - Owner=INST in ADDR without bus_gnt in the same cycle: abort immediately and go to IDLE; inst_ready is never pulsed.
  - Owner=INST in ADDR with bus_gnt in the same cycle, or owner=INST in RESP: set the drop flag. The transaction finishes on the bus, but inst_ready is suppressed.
  - Owner=DATA: cancel has no effect.
  - Cancel in IDLE: no effect.
- A request with no owner is never issued. A single transaction is outstanding at a time.
- Pending-request latches are not re-sampled until the FSM returns to IDLE.

## Timing
- Reset values:
  - State IDLE.
  - bus_req, bus_wr, inst_ready, data_ready and bus_timeout are 0.
  - bus_wstrb = 0.
  - bus_addr, bus_wdata, inst_rdata and data_rdata are 0.
  - Drop flag 0, watchdog counter 0.
- Minimum latency, zero-wait bus:
  - Request seen in IDLE at cycle 0.
  - bus_req=1 at cycle 1; bus_gnt arrives at cycle 1.
  - bus_rvalid arrives at cycle 2.
  - ready pulse and rdata at cycle 3.
- ready is registered and high for exactly one cycle. rdata holds its value until the next capture.
- The bridge returns to IDLE in the same cycle as the ready pulse, so a held request can re-arbitrate in that cycle. The core drops inst_req/data_req in the ready cycle when it has no further request.
- bus_req and the address-phase fields stay stable from entry into ADDR until bus_gnt.
- bus_rvalid outside RESP is ignored.
- Watchdog counter is $clog2(TIMEOUT+1) bits wide and saturates; bus_timeout clears only on reset.
- Asserting reset mid-transaction forces IDLE immediately. No ready pulse is produced for the interrupted request.

## Structure
- Shared package: FSM state encoding (IDLE=2'd0, ADDR=2'd1, RESP=2'd2), owner encoding (INST=1'b0, DATA=1'b1), and the TIMEOUT_DATA constant 32'hDEADBEEF.
- One natural sub-module, bridge_watchdog: counter plus sticky error flag, with clear/enable inputs and an expired output.

## Test plan
- Zero-wait load: data_req=1, wen=0, addr=0x1000_0040; bus gnt at cycle 1, rvalid at cycle 2 with rdata=0x1234_5678 -> data_ready=1 and data_rdata=0x1234_5678 at cycle 3, exactly one pulse.
- Simultaneous requests: inst_req and data_req both set at cycle 0, data is a store with wen=4'b0011 and wdata=0xAABB_CCDD -> first bus_req has wr=1, wstrb=4'b0011, addr=data_addr; the fetch is issued only after data_ready.
- Grant wait: bus_gnt held low for 5 cycles -> bus_req and bus_addr stable for all 5 cycles; ready arrives 2 cycles after the gnt-plus-rvalid sequence completes.
- Cancel during fetch:
  - cancel in RESP of a fetch, rvalid arriving 2 cycles later -> no inst_ready; the next fetch to 0xBFC0_0380 completes normally.
  - cancel in ADDR before gnt -> bus_req drops the next cycle.
- Timeout with TIMEOUT=8: gnt given, rvalid never arrives -> 8 cycles later data_ready=1 with rdata=0xDEADBEEF; bus_timeout=1 and stays set until reset.
- Asynchronous reset asserted in RESP -> all outputs take their reset values immediately; bus_rvalid arriving after reset release produces no ready pulse.
